// File: rtl/lock_pkg.sv
// Shared definitions for the lock keypad front end: key count, FSM encoding and
// small combinational helpers used on the debounced key pattern.
package lock_pkg;

  localparam int unsigned NUM_KEYS = 9;

  localparam logic [1:0] KP_IDLE     = 2'd0;
  localparam logic [1:0] KP_DEBOUNCE = 2'd1;
  localparam logic [1:0] KP_PRESSED  = 2'd2;
  localparam logic [1:0] KP_RELEASE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle     = KP_IDLE,
    StDebounce = KP_DEBOUNCE,
    StPressed  = KP_PRESSED,
    StRelease  = KP_RELEASE
  } kp_state_e;

  // One-hot of the highest set bit; higher key index wins.
  function automatic logic [NUM_KEYS-1:0] top_onehot(input logic [NUM_KEYS-1:0] v);
    logic [NUM_KEYS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // True when more than one bit is set.
  function automatic logic has_multi(input logic [NUM_KEYS-1:0] v);
    return |(v & (v - NUM_KEYS'(1)));
  endfunction

endpackage

// File: rtl/keypad_front_if.sv
// Keypad front-end bus: raw button levels in, debounced key event out.
interface keypad_front_if;

  logic [lock_pkg::NUM_KEYS-1:0] raw_keys;
  logic [lock_pkg::NUM_KEYS-1:0] key_vec;
  logic                          key_strobe;
  logic                          key_busy;
  logic                          multi_key;

  // Board/consumer side: drives buttons, observes key events.
  modport master (
    output raw_keys,
    input  key_vec,
    input  key_strobe,
    input  key_busy,
    input  multi_key
  );

  // Debouncer side.
  modport slave (
    input  raw_keys,
    output key_vec,
    output key_strobe,
    output key_busy,
    output multi_key
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture to resolve metastability on the raw pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_front.sv
// Debounced keypad front end: synchronises the raw buttons, waits for a stable
// pattern, then emits one strobe and a held one-hot of the highest pressed key.
module keypad_front
  import lock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_front_if.slave kp
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES - 1) >= (64'd1 << CNT_W)) begin : g_param_err
    $error("keypad_front: DEBOUNCE_CYCLES must be >= 2 and DEBOUNCE_CYCLES-1 must fit in CNT_W");
  end

  logic [NUM_KEYS-1:0] w_sk;
  kp_state_e           r_state, w_state_d;
  logic [NUM_KEYS-1:0] r_snap, w_snap_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d, w_cnt_inc;
  logic [NUM_KEYS-1:0] r_key_vec, w_key_vec_d;
  logic                r_key_strobe, w_key_strobe_d;
  logic                r_multi_key, w_multi_key_d;

  sync2 #(
    .WIDTH (NUM_KEYS)
  ) u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (kp.raw_keys),
    .o_q   (w_sk)
  );

  // Saturating increment; the count never wraps.
  assign w_cnt_inc = (r_cnt == CntLast) ? r_cnt : r_cnt + CNT_W'(1);

  // Next-state logic and registered-output precomputation.
  always_comb begin
    w_state_d = r_state;
    w_snap_d  = r_snap;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_sk != '0) begin
          w_snap_d  = w_sk;
          w_cnt_d   = '0;
          w_state_d = StDebounce;
        end
      end
      StDebounce: begin
        if (w_sk == '0) begin
          w_state_d = StIdle;
        end else if (w_sk != r_snap) begin
          w_snap_d = w_sk;
          w_cnt_d  = '0;
        end else begin
          w_cnt_d = w_cnt_inc;
          if (r_cnt == CntLast) w_state_d = StPressed;
        end
      end
      StPressed: begin
        // Any change to the held pattern only leads to release, never a new event.
        if (w_sk != r_snap) begin
          w_cnt_d   = '0;
          w_state_d = StRelease;
        end
      end
      StRelease: begin
        if (w_sk != '0) begin
          w_cnt_d = '0;
        end else begin
          w_cnt_d = w_cnt_inc;
          if (r_cnt == CntLast) w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    w_key_strobe_d = (w_state_d == StPressed) && (r_state != StPressed);
    w_key_vec_d    = (w_state_d == StPressed) ? top_onehot(w_snap_d) : '0;
    w_multi_key_d  = (w_state_d == StPressed) && has_multi(w_snap_d);
  end

  // State, debounce bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_snap       <= '0;
      r_cnt        <= '0;
      r_key_vec    <= '0;
      r_key_strobe <= 1'b0;
      r_multi_key  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_snap       <= w_snap_d;
      r_cnt        <= w_cnt_d;
      r_key_vec    <= w_key_vec_d;
      r_key_strobe <= w_key_strobe_d;
      r_multi_key  <= w_multi_key_d;
    end
  end

  assign kp.key_vec    = r_key_vec;
  assign kp.key_strobe = r_key_strobe;
  assign kp.multi_key  = r_multi_key;
  assign kp.key_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_keypad_front.sv
// Bench for keypad_front: run-length reference model checked every cycle,
// directed scenarios with hand-computed expectations, then random button traffic.
module tb_keypad_front;

  localparam int unsigned D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_front_if kp ();

  keypad_front #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int n_strobes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pattern accepted once the synchronised value has stayed the
  // same nonzero value for D+1 consecutive samples while waiting; released after
  // D zero samples seen after the held pattern first changed.
  logic [8:0] m_s1 = '0, m_s2 = '0, m_last = '0, m_pat = '0;
  int         m_run = 0, m_zrun = 0, m_phase = 0;  // phase: 0 wait, 1 held, 2 releasing
  logic       m_strobe = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [8:0] sk;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_last = '0; m_pat = '0;
      m_run = 0; m_zrun = 0; m_phase = 0; m_strobe = 1'b0;
    end else begin
      sk       = m_s2;
      m_s2     = m_s1;
      m_s1     = kp.raw_keys;
      m_strobe = 1'b0;
      case (m_phase)
        0: begin
          if (sk == 9'h0) m_run = 0;
          else if (sk == m_last) m_run++;
          else m_run = 1;
          m_last = sk;
          if (m_run == D + 1) begin
            m_phase  = 1;
            m_pat    = sk;
            m_strobe = 1'b1;
          end
        end
        1: begin
          if (sk != m_pat) begin
            m_phase = 2;
            m_zrun  = 0;
          end
        end
        default: begin
          if (sk != 9'h0) m_zrun = 0;
          else m_zrun++;
          if (m_zrun == D) begin
            m_phase = 0;
            m_run   = 0;
            m_last  = '0;
          end
        end
      endcase
    end
  end

  function automatic logic [8:0] exp_onehot(input logic [8:0] p);
    for (int i = 8; i >= 0; i--) if (p[i]) return 9'(1) << i;
    return 9'h0;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("key_vec",    kp.key_vec,    (m_phase == 1) ? exp_onehot(m_pat) : 9'h0);
    check("key_strobe", kp.key_strobe, m_strobe);
    check("multi_key",  kp.multi_key,  (m_phase == 1) && ($countones(m_pat) > 1));
    check("key_busy",   kp.key_busy,   (m_phase != 0) || (m_run > 0));
    if (kp.key_strobe) n_strobes++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int first;
    int s0;
    logic [8:0] vec_at;
    logic [8:0] p;

    // 1: reset with a key held, then normal debounce to one strobe at cycle 7
    kp.raw_keys = 9'h010;
    rst_n = 1'b0;
    tick(3);
    check("t1_rst_vec",    kp.key_vec,    9'h0);
    check("t1_rst_strobe", kp.key_strobe, 1'b0);
    check("t1_rst_busy",   kp.key_busy,   1'b0);
    check("t1_rst_multi",  kp.multi_key,  1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    first  = 0;
    vec_at = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (kp.key_strobe && first == 0) begin
        first  = c;
        vec_at = kp.key_vec;
      end
    end
    check("t1_strobe_cycle", first, 7);
    check("t1_key_vec", vec_at, 9'h010);
    kp.raw_keys = 9'h0;
    tick(10);
    check("t1_idle", kp.key_busy, 1'b0);

    // 2: short glitch never produces an event
    s0 = n_strobes;
    kp.raw_keys = 9'h004;
    tick(3);
    kp.raw_keys = 9'h0;
    tick(6);
    check("t2_no_strobe", n_strobes - s0, 0);
    check("t2_busy", kp.key_busy, 1'b0);
    check("t2_vec",  kp.key_vec,  9'h0);

    // 3: several keys: highest index wins and multi_key is raised
    s0 = n_strobes;
    kp.raw_keys = 9'h0A1;
    tick(10);
    check("t3_one_strobe", n_strobes - s0, 1);
    check("t3_vec",   kp.key_vec,   9'h080);
    check("t3_multi", kp.multi_key, 1'b1);
    kp.raw_keys = 9'h0;
    tick(10);

    // 4: bounce during release restarts the count and never re-strobes
    s0 = n_strobes;
    kp.raw_keys = 9'h002;
    tick(10);
    for (int i = 0; i < 5; i++) begin
      kp.raw_keys = 9'h0;
      tick(2);
      kp.raw_keys = 9'h002;
      tick(2);
    end
    kp.raw_keys = 9'h0;
    tick(5);
    check("t4_busy_before", kp.key_busy, 1'b1);
    tick(1);
    check("t4_busy_after", kp.key_busy, 1'b0);
    check("t4_one_strobe", n_strobes - s0, 1);

    // 5: adding a key while pressed goes to release without a new event
    kp.raw_keys = 9'h008;
    tick(8);
    check("t5_vec_held", kp.key_vec, 9'h008);
    s0 = n_strobes;
    kp.raw_keys = 9'h108;
    tick(3);
    check("t5_vec_cleared", kp.key_vec, 9'h0);
    tick(10);
    check("t5_busy", kp.key_busy, 1'b1);
    check("t5_no_strobe", n_strobes - s0, 0);
    kp.raw_keys = 9'h0;
    tick(8);

    // 6: async reset mid-debounce and mid-pressed clears outputs at once
    kp.raw_keys = 9'h040;
    tick(4);
    check("t6_in_debounce", kp.key_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_deb_busy",   kp.key_busy,   1'b0);
    check("t6_deb_strobe", kp.key_strobe, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = n_strobes;
    tick(8);
    check("t6_held_strobe", n_strobes - s0, 1);
    check("t6_held_vec", kp.key_vec, 9'h040);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_prs_vec",   kp.key_vec,   9'h0);
    check("t6_prs_busy",  kp.key_busy,  1'b0);
    check("t6_prs_multi", kp.multi_key, 1'b0);
    kp.raw_keys = 9'h0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);

    // Random button traffic with occasional mid-cycle resets
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 9) < 3) p = 9'h0;
      else if ($urandom_range(0, 1) == 0) p = 9'(1) << $urandom_range(0, 8);
      else p = 9'($urandom_range(1, 511));
      kp.raw_keys = p;
      tick($urandom_range(1, 12));
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end
    kp.raw_keys = 9'h0;
    tick(12);
    check("end_idle", kp.key_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
